// File: rtl/i2c_text_register_if.sv
// Register bus from the I2C slave plus the cell-write stream toward the text sink.
// Cell write: a transfer happens on a rising edge where wr_valid && wr_ready; while wr_valid=1 and wr_ready=0 the payload holds.
interface i2c_text_register_if;
  logic [7:0] addr;
  logic [7:0] dataIn;
  logic       writeEn;
  logic [7:0] dataOut;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_char;
  logic [7:0] wr_x;
  logic [7:0] wr_y;
  logic [7:0] wr_attr1;
  logic [7:0] wr_attr2;
  logic       state_dbg;

  modport slave (
    input  addr, dataIn, writeEn, wr_ready,
    output dataOut, wr_valid, wr_char, wr_x, wr_y, wr_attr1, wr_attr2, state_dbg
  );

  modport master (
    output addr, dataIn, writeEn, wr_ready,
    input  dataOut, wr_valid, wr_char, wr_x, wr_y, wr_attr1, wr_attr2, state_dbg
  );
endinterface

// File: rtl/i2c_text_register.sv
// Text-mode register file: cursor/attribute registers, a character FIFO and a
// clear-screen engine feeding a valid/ready cell-write stream.
module i2c_text_register #(
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int FIFO_DEPTH = 8
) (
  input logic clk,
  input logic rst_n,
  i2c_text_register_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [7:0] MAX_X = 8'(COLS - 1);
  localparam logic [7:0] MAX_Y = 8'(ROWS - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
  typedef struct packed {
    logic [7:0] ch;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] a1;
    logic [7:0] a2;
  } cell_t;

  state_t         state;
  logic [7:0]     x_q, y_q, attr1_q, attr2_q, last_q, dout_q;
  logic [5:0]     ctrl_q;
  logic           overflow_q;
  cell_t          mem [FIFO_DEPTH];
  logic [PW-1:0]  wptr, rptr;
  logic [CW-1:0]  cnt;
  logic [7:0]     cx, cy, clr_a1, clr_a2;

  logic       fifo_full, fifo_empty, valid, hs, pop, push, drop;
  logic       char_wr, ctrl_wr, clear_done;
  logic [7:0] nx, ny, rdata, status;
  cell_t      head;

  assign char_wr    = bus.writeEn && (bus.addr == 8'h00);
  assign ctrl_wr    = bus.writeEn && (bus.addr == 8'h05);
  assign fifo_full  = (cnt == CW'(FIFO_DEPTH));
  assign fifo_empty = (cnt == '0);
  assign valid      = (state == CLEAR) || !fifo_empty;
  assign hs         = valid && bus.wr_ready;
  assign pop        = (state == IDLE) && hs;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push       = char_wr && (!fifo_full || pop);
  assign drop       = char_wr && !push;
  assign clear_done = (state == CLEAR) && hs && (cx == MAX_X) && (cy == MAX_Y);
  assign status     = {state == CLEAR, overflow_q, fifo_full, fifo_empty, 4'(cnt)};

  assign head = (state == CLEAR) ? cell_t'{8'h20, cx, cy, clr_a1, clr_a2} : mem[rptr];

  assign bus.wr_valid  = valid;
  assign bus.wr_char   = head.ch;
  assign bus.wr_x      = head.x;
  assign bus.wr_y      = head.y;
  assign bus.wr_attr1  = head.a1;
  assign bus.wr_attr2  = head.a2;
  assign bus.dataOut   = dout_q;
  assign bus.state_dbg = state;

  always_comb begin
    nx = x_q;
    ny = y_q;
    if (ctrl_q[0]) begin
      if (x_q != MAX_X) begin
        nx = x_q + 8'd1;
      end else if (y_q != MAX_Y) begin
        nx = 8'd0;
        ny = y_q + 8'd1;
      end else if (ctrl_q[1]) begin
        nx = 8'd0;
        ny = 8'd0;
      end
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (bus.addr)
      8'h00: rdata = last_q;
      8'h01: rdata = x_q;
      8'h02: rdata = y_q;
      8'h03: rdata = attr1_q;
      8'h04: rdata = attr2_q;
      8'h05: rdata = {2'b00, ctrl_q};
      8'h06: rdata = status;
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x_q        <= 8'h00;
      y_q        <= 8'h00;
      attr1_q    <= 8'h07;
      attr2_q    <= 8'h00;
      ctrl_q     <= 6'h03;
      last_q     <= 8'h00;
      dout_q     <= 8'h00;
      overflow_q <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      cx         <= 8'h00;
      cy         <= 8'h00;
      clr_a1     <= 8'h00;
      clr_a2     <= 8'h00;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      dout_q <= rdata;

      if (bus.writeEn) begin
        case (bus.addr)
          8'h00: last_q  <= bus.dataIn;
          8'h01: x_q     <= (bus.dataIn > MAX_X) ? MAX_X : bus.dataIn;
          8'h02: y_q     <= (bus.dataIn > MAX_Y) ? MAX_Y : bus.dataIn;
          8'h03: attr1_q <= bus.dataIn;
          8'h04: attr2_q <= bus.dataIn;
          8'h05: ctrl_q  <= bus.dataIn[5:0];
          default: ;
        endcase
      end

      if (push) begin
        mem[wptr] <= cell_t'{bus.dataIn, x_q, y_q, attr1_q, attr2_q};
        wptr      <= wptr + 1'b1;
        x_q       <= nx;
        y_q       <= ny;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase

      if (drop) overflow_q <= 1'b1;
      else if (ctrl_wr && bus.dataIn[6]) overflow_q <= 1'b0;

      case (state)
        IDLE: begin
          if (ctrl_wr && bus.dataIn[7]) begin
            state  <= CLEAR;
            cx     <= 8'h00;
            cy     <= 8'h00;
            clr_a1 <= attr1_q;
            clr_a2 <= attr2_q;
          end
        end
        CLEAR: begin
          if (hs) begin
            if (cx != MAX_X) begin
              cx <= cx + 8'd1;
            end else begin
              cx <= 8'h00;
              if (cy != MAX_Y) cy <= cy + 8'd1;
              else cy <= 8'h00;
            end
          end
          // Clear exit homes the cursor, overriding any autoinc on this edge.
          if (clear_done) begin
            state <= IDLE;
            x_q   <= 8'h00;
            y_q   <= 8'h00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_text_register.sv
// Directed bench: an 80x30 instance (a) and a 4x2 instance (b) share clock and reset.
module tb_i2c_text_register;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_text_register_if bus_a ();
  i2c_text_register_if bus_b ();

  i2c_text_register #(.COLS(80), .ROWS(30), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  i2c_text_register #(.COLS(4), .ROWS(2), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [39:0] exp_q[$];
  logic [39:0] got_a[$];
  logic [39:0] got_b[$];

  always @(negedge clk) begin
    if (bus_a.wr_valid && bus_a.wr_ready)
      got_a.push_back({bus_a.wr_char, bus_a.wr_x, bus_a.wr_y, bus_a.wr_attr1, bus_a.wr_attr2});
    if (bus_b.wr_valid && bus_b.wr_ready)
      got_b.push_back({bus_b.wr_char, bus_b.wr_x, bus_b.wr_y, bus_b.wr_attr1, bus_b.wr_attr2});
  end

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_reg(input bit b, input logic [7:0] a, input logic [7:0] d);
    if (b) begin
      bus_b.addr = a; bus_b.dataIn = d; bus_b.writeEn = 1'b1;
    end else begin
      bus_a.addr = a; bus_a.dataIn = d; bus_a.writeEn = 1'b1;
    end
    @(posedge clk); #1;
    bus_a.writeEn = 1'b0;
    bus_b.writeEn = 1'b0;
  endtask

  task automatic read_check(input bit b, input logic [7:0] a, input logic [7:0] exp, input string tag);
    if (b) bus_b.addr = a;
    else   bus_a.addr = a;
    @(posedge clk); #1;
    check(tag, b ? bus_b.dataOut : bus_a.dataOut, exp);
  endtask

  task automatic cmp_cells(input bit b, input string tag);
    logic [39:0] g[$];
    if (b) g = got_b;
    else   g = got_a;
    check({tag, "_count"}, 40'(g.size()), 40'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < g.size(); i++)
      check($sformatf("%s_cell%0d", tag, i), g[i], exp_q[i]);
    exp_q.delete();
    got_a.delete();
    got_b.delete();
  endtask

  initial begin
    bus_a.addr = 8'h00; bus_a.dataIn = 8'h00; bus_a.writeEn = 1'b0; bus_a.wr_ready = 1'b0;
    bus_b.addr = 8'h00; bus_b.dataIn = 8'h00; bus_b.writeEn = 1'b0; bus_b.wr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_dout", bus_a.dataOut, 8'h00);
    check("rst_valid", bus_a.wr_valid, 1'b0);
    check("rst_state", bus_a.state_dbg, 1'b0);
    read_check(0, 8'h01, 8'h00, "rst_x");
    read_check(0, 8'h03, 8'h07, "rst_attr1");
    read_check(0, 8'h05, 8'h03, "rst_ctrl");
    read_check(0, 8'h06, 8'h10, "rst_status");

    // Autoinc across the end of a row
    bus_a.wr_ready = 1'b1;
    got_a.delete();
    write_reg(0, 8'h01, 8'd79);
    write_reg(0, 8'h02, 8'd2);
    write_reg(0, 8'h00, 8'h41);
    repeat (4) @(posedge clk); #1;
    exp_q.push_back({8'h41, 8'd79, 8'd2, 8'h07, 8'h00});
    cmp_cells(0, "row_end");
    read_check(0, 8'h01, 8'd0, "row_end_x");
    read_check(0, 8'h02, 8'd3, "row_end_y");

    // Clamping
    write_reg(0, 8'h01, 8'd200);
    write_reg(0, 8'h02, 8'd40);
    read_check(0, 8'h01, 8'd79, "clamp_x");
    read_check(0, 8'h02, 8'd29, "clamp_y");

    // Last cell with wrap=0 then wrap=1
    write_reg(0, 8'h05, 8'h01);
    write_reg(0, 8'h00, 8'h42);
    read_check(0, 8'h01, 8'd79, "nowrap_x");
    read_check(0, 8'h02, 8'd29, "nowrap_y");
    write_reg(0, 8'h05, 8'h03);
    write_reg(0, 8'h00, 8'h42);
    read_check(0, 8'h01, 8'd0, "wrap_x");
    read_check(0, 8'h02, 8'd0, "wrap_y");
    read_check(0, 8'h00, 8'h42, "last_char");
    repeat (2) @(posedge clk); #1;
    exp_q.push_back({8'h42, 8'd79, 8'd29, 8'h07, 8'h00});
    exp_q.push_back({8'h42, 8'd79, 8'd29, 8'h07, 8'h00});
    cmp_cells(0, "wrap");

    // Unmapped address
    write_reg(0, 8'h07, 8'hFF);
    read_check(0, 8'h07, 8'h00, "unmapped");

    // Overflow with a stalled sink
    bus_a.wr_ready = 1'b0;
    write_reg(0, 8'h03, 8'h1E);
    for (int i = 0; i < 9; i++) write_reg(0, 8'h00, 8'(8'h30 + i));
    read_check(0, 8'h06, 8'h68, "ovf_status");
    read_check(0, 8'h01, 8'd8, "ovf_x");
    read_check(0, 8'h02, 8'd0, "ovf_y");
    read_check(0, 8'h00, 8'h38, "ovf_last");
    write_reg(0, 8'h05, 8'h43);
    read_check(0, 8'h06, 8'h28, "ovf_cleared");
    read_check(0, 8'h05, 8'h03, "ctrl_readback");
    bus_a.wr_ready = 1'b1;
    repeat (12) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) exp_q.push_back({8'(8'h30 + i), 8'(i), 8'd0, 8'h1E, 8'h00});
    cmp_cells(0, "drain");
    read_check(0, 8'h06, 8'h10, "drain_status");

    // Clear screen on 4x2 with a character queued mid-clear
    bus_b.wr_ready = 1'b1;
    write_reg(1, 8'h03, 8'h4C);
    write_reg(1, 8'h04, 8'h81);
    write_reg(1, 8'h01, 8'd2);
    write_reg(1, 8'h02, 8'd1);
    got_b.delete();
    write_reg(1, 8'h05, 8'h83);
    check("clr_state", bus_b.state_dbg, 1'b1);
    bus_b.addr = 8'h06;
    @(posedge clk); #1;
    check("clr_busy", bus_b.dataOut[7], 1'b1);
    write_reg(1, 8'h00, 8'h55);
    repeat (12) @(posedge clk); #1;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++) exp_q.push_back({8'h20, 8'(x), 8'(y), 8'h4C, 8'h81});
    exp_q.push_back({8'h55, 8'd2, 8'd1, 8'h4C, 8'h81});
    cmp_cells(1, "clear");
    read_check(1, 8'h01, 8'd0, "clr_x");
    read_check(1, 8'h02, 8'd0, "clr_y");
    read_check(1, 8'h06, 8'h10, "clr_status");

    // Reset mid-clear with pending entries
    bus_b.wr_ready = 1'b0;
    write_reg(1, 8'h05, 8'h83);
    for (int i = 0; i < 3; i++) write_reg(1, 8'h00, 8'(8'h61 + i));
    check("pre_rst_valid", bus_b.wr_valid, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", bus_b.wr_valid, 1'b0);
    check("rst_mid_char", bus_b.wr_char, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    got_b.delete();
    read_check(1, 8'h01, 8'h00, "rst2_x");
    read_check(1, 8'h03, 8'h07, "rst2_attr1");
    read_check(1, 8'h04, 8'h00, "rst2_attr2");
    read_check(1, 8'h05, 8'h03, "rst2_ctrl");
    read_check(1, 8'h06, 8'h10, "rst2_status");
    bus_b.wr_ready = 1'b1;
    repeat (20) @(posedge clk); #1;
    cmp_cells(1, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
